// File: rtl/milano_pkg.sv
// Shared fetch-path types and constants.
// Used by the IF/ID decoupling buffer.
package milano_pkg;

  localparam int unsigned FE_DATA_W = 32;
  localparam int unsigned FE_ADDR_W = 32;

  localparam logic [FE_DATA_W-1:0] NOP_INSTR =
    32'h0000_0013;

  typedef struct packed {
    logic [FE_DATA_W-1:0] rdata;
    logic [FE_ADDR_W-1:0] addr;
    logic                 err;
  } fetch_entry_t;

endpackage

// File: rtl/if_id_buf.sv
// IF/ID decoupling FIFO with NOP fill on empty.
// Head is presented straight from storage.
module if_id_buf
  import milano_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter logic [DATA_W-1:0] NOP_INSTR =
    DATA_W'(milano_pkg::NOP_INSTR),
  localparam int unsigned PTR_W =
    $clog2(DEPTH),
  localparam int unsigned LVL_W =
    $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] instr_rdata_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  input  logic              instr_err_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] instr_rdata_id_o,
  output logic [ADDR_W-1:0] instr_addr_id_o,
  output logic              instr_err_id_o,
  output logic [LVL_W-1:0]  level_o
);

  localparam logic [PTR_W-1:0] PTR_LAST =
    PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL =
    LVL_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     wr_entry;
  fetch_entry_t     head;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  logic             push;
  logic             pop;
  logic             empty;

  assign empty = (level_q == '0);

  assign in_ready_o =
    (level_q < LVL_FULL) && !flush_i;
  assign out_valid_o = !empty;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  // Pack the incoming fetch into an entry.
  always_comb begin
    wr_entry       = '0;
    wr_entry.rdata = FE_DATA_W'(instr_rdata_i);
    wr_entry.addr  = FE_ADDR_W'(instr_addr_i);
    wr_entry.err   = instr_err_i;
  end

  // Pointer wrap and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ?
          '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ?
          '0 : rd_ptr_q + 1'b1;
      end
      unique case (1'b1)
        push && !pop: level_d = level_q + 1'b1;
        pop && !push: level_d = level_q - 1'b1;
        default:      level_d = level_q;
      endcase
    end
  end

  // Control state; reset wins over flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is never reset; level gates it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Head view, NOP-filled while empty.
  always_comb begin
    head = mem_q[rd_ptr_q];
    instr_rdata_id_o = NOP_INSTR;
    instr_addr_id_o  = '0;
    instr_err_id_o   = 1'b0;
    if (!empty) begin
      instr_rdata_id_o = DATA_W'(head.rdata);
      instr_addr_id_o  = ADDR_W'(head.addr);
      instr_err_id_o   = head.err;
    end
  end

  assign level_o = level_q;

endmodule

// File: tb/tb_if_id_buf.sv
// Random and directed bench for if_id_buf.
// Two instances (DEPTH 2 and 3), one queue model each.
module tb_if_id_buf;
  import milano_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] rdata;
  logic [31:0] addr;
  logic        err;
  logic [1:0]  ordy;

  logic [1:0]  irdy;
  logic [1:0]  ovld;
  logic [1:0]  oerr;
  logic [31:0] od [2];
  logic [31:0] oa [2];
  logic [1:0]  lvl2;
  logic [1:0]  lvl3;

  int total = 0;
  int bad   = 0;

  logic [64:0] mq [2][$];
  int mdep [2] = '{2, 3};
  int tok = 0;

  if_id_buf #(.DEPTH(2)) u_dut2 (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .in_valid_i       (in_valid),
    .in_ready_o       (irdy[0]),
    .instr_rdata_i    (rdata),
    .instr_addr_i     (addr),
    .instr_err_i      (err),
    .out_valid_o      (ovld[0]),
    .out_ready_i      (ordy[0]),
    .instr_rdata_id_o (od[0]),
    .instr_addr_id_o  (oa[0]),
    .instr_err_id_o   (oerr[0]),
    .level_o          (lvl2)
  );

  if_id_buf #(.DEPTH(3)) u_dut3 (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .in_valid_i       (in_valid),
    .in_ready_o       (irdy[1]),
    .instr_rdata_i    (rdata),
    .instr_addr_i     (addr),
    .instr_err_i      (err),
    .out_valid_o      (ovld[1]),
    .out_ready_i      (ordy[1]),
    .instr_rdata_id_o (od[1]),
    .instr_addr_id_o  (oa[1]),
    .instr_err_id_o   (oerr[1]),
    .level_o          (lvl3)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(
    input logic        v,
    input logic [1:0]  r,
    input logic        f,
    input logic        rs,
    input logic [31:0] d,
    input logic [31:0] a,
    input logic        e
  );
    logic [64:0] h;
    logic [1:0]  lv;
    bit          pu [2];
    bit          po [2];
    int          sz;
    rst = rs; flush = f; in_valid = v;
    ordy = r; rdata = d; addr = a; err = e;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sz = mq[i].size();
      h  = (sz != 0) ? mq[i][0]
                     : {1'b0, 32'h0, 32'h0000_0013};
      lv = (i == 0) ? lvl2 : lvl3;
      check($sformatf("valid%0d", i),
            64'(ovld[i]), 64'(sz != 0));
      check($sformatf("data%0d", i),
            64'(od[i]), 64'(h[31:0]));
      check($sformatf("addr%0d", i),
            64'(oa[i]), 64'(h[63:32]));
      check($sformatf("err%0d", i),
            64'(oerr[i]), 64'(h[64]));
      check($sformatf("level%0d", i),
            64'(lv), 64'(sz));
      check($sformatf("ready%0d", i),
            64'(irdy[i]),
            64'((sz < mdep[i]) && !f));
      pu[i] = v && (sz < mdep[i]) && !f;
      po[i] = (sz != 0) && r[i];
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rs || f) begin
        mq[i].delete();
      end else begin
        if (po[i]) void'(mq[i].pop_front());
        if (pu[i]) mq[i].push_back({e, a, d});
      end
    end
    #1;
  endtask

  task automatic push_tok(
    input logic [1:0] r,
    input logic       e
  );
    tok++;
    cyc(1'b1, r, 1'b0, 1'b0,
        32'hA000_0000 + 32'(tok),
        32'h1000 + 32'(tok * 4), e);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    ordy = 2'b00; rdata = '0; addr = '0;
    err = 1'b0;
    @(posedge clk);
    #1;

    cyc(0, 2'b00, 0, 1, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 0);
    check("rst_valid", 64'(ovld[0]), 64'd0);
    check("rst_nop", 64'(od[0]), 64'h13);
    check("rst_level", 64'(lvl2), 64'd0);
    check("rst_ready", 64'(irdy[0]), 64'd1);

    cyc(1, 2'b11, 0, 0, 32'h11, 32'h100, 0);
    cyc(1, 2'b11, 0, 0, 32'h22, 32'h104, 0);
    cyc(1, 2'b11, 0, 0, 32'h33, 32'h108, 0);
    cyc(0, 2'b11, 0, 0, 0, 0, 0);
    cyc(0, 2'b11, 0, 0, 0, 0, 0);

    cyc(1, 2'b00, 0, 0, 32'h44, 32'h200, 0);
    cyc(1, 2'b00, 0, 0, 32'h55, 32'h204, 0);
    check("full_level", 64'(lvl2), 64'd2);
    check("full_ready", 64'(irdy[0]), 64'd0);
    cyc(1, 2'b00, 0, 0, 32'h66, 32'h208, 0);
    cyc(1, 2'b11, 0, 0, 32'h66, 32'h208, 0);
    cyc(1, 2'b11, 0, 0, 32'h66, 32'h208, 0);
    for (int k = 0; k < 4; k++)
      cyc(0, 2'b11, 0, 0, 0, 0, 0);

    push_tok(2'b00, 0);
    push_tok(2'b00, 0);
    cyc(1, 2'b11, 1, 0, 32'h77, 32'h300, 0);
    check("flush_valid", 64'(ovld[0]), 64'd0);
    check("flush_level", 64'(lvl2), 64'd0);
    cyc(0, 2'b11, 0, 0, 0, 0, 0);

    push_tok(2'b11, 0);
    push_tok(2'b11, 1);
    push_tok(2'b11, 0);
    for (int k = 0; k < 3; k++)
      cyc(0, 2'b11, 0, 0, 0, 0, 0);

    for (int k = 0; k < 400; k++) begin
      tok++;
      cyc(($urandom % 4) != 0,
          2'($urandom),
          ($urandom % 20) == 0,
          ($urandom % 60) == 0,
          $urandom,
          32'h4000 + 32'(tok * 4),
          ($urandom % 5) == 0);
    end

    for (int k = 0; k < 5; k++)
      cyc(0, 2'b11, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
